alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning execute-phase cycles per operation (legal 1..4).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has an operation pending.
REQ-005 SHALL have port req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 ADD, 11 SUB.
REQ-006 SHALL have port req0_a  input  32  requester 0 operand A.
REQ-007 SHALL have port req0_b  input  32  requester 0 operand B.
REQ-008 SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-009 SHALL have ports req1_valid, req1_op, req1_a, req1_b, req1_ready with the same directions, widths and meanings for requester 1.
REQ-010 SHALL have port resp_valid  output  1  result available.
REQ-011 SHALL have port resp_id  output  1  index of the requester that owns the result.
REQ-012 SHALL have port resp_result  output  32  operation result.
REQ-013 SHALL have port resp_zero  output  1  high when resp_result equals 0.
REQ-014 SHALL have port resp_ready  input  1  consumer accepts the result.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, EXEC, DONE.
REQ-016 In IDLE with any reqN_valid high, SHALL grant exactly one requester, latch its op/a/b and id, assert that reqN_ready combinationally in that cycle, and move to EXEC.
REQ-017 reqN_ready SHALL be high only in IDLE and only for the granted requester; it SHALL be low in EXEC and DONE.
REQ-018 With both valid in IDLE, the winner SHALL be chosen by a 1-bit round-robin pointer; after each grant the pointer SHALL point to the other requester.
REQ-019 With only one valid, that requester SHALL be granted regardless of the pointer, and the pointer SHALL still update per REQ-018.
REQ-020 EXEC SHALL last exactly LATENCY cycles, counted by an internal counter cleared on grant; result SHALL be registered on the last EXEC cycle and the FSM SHALL move to DONE.
REQ-021 AND/OR SHALL be bitwise on 32 bits; ADD and SUB SHALL be modulo 2^32 with carry/borrow discarded.
REQ-022 In DONE, resp_valid, resp_id, resp_result, resp_zero SHALL be held stable until resp_valid and resp_ready are both high.
REQ-023 On the handshake cycle the FSM SHALL return to IDLE; no new grant SHALL occur in that same cycle (minimum issue interval LATENCY+2 cycles).
REQ-024 resp_valid SHALL be low in IDLE and EXEC; resp_ready SHALL be ignored outside DONE.
REQ-025 Changes on reqN_op/a/b after acceptance SHALL not affect the in-flight result.

Reset
REQ-026 With rst high at a clock edge, SHALL enter IDLE and clear resp_valid, resp_id, resp_result, resp_zero, pointer (to requester 0) and counter, including mid-EXEC or mid-DONE; the in-flight operation SHALL be discarded.
REQ-027 During a cycle with rst high, reqN_ready SHALL be low.

Configuration
REQ-028 Macro ALU_ARBITER_FIXED_PRIO_EN: when defined, requester 0 SHALL always win when both are valid and the pointer SHALL be absent; when undefined, round-robin per REQ-018 SHALL apply.

Verification
REQ-029 Reset mid-EXEC: grant req0 ADD, assert rst in EXEC cycle 1 -> next cycle IDLE, resp_valid=0, resp_result=0, no response ever issued for it.
REQ-030 Single op: req0 SUB a=5 b=7, LATENCY=2, resp_ready=1 -> resp_valid high 3 cycles after accept, resp_result=0xFFFFFFFE, resp_id=0, resp_zero=0.
REQ-031 Round-robin: both valid continuously, AND and OR ops -> grants alternate 0,1,0,1 (undefined macro); with ALU_ARBITER_FIXED_PRIO_EN -> all grants to 0.
REQ-032 Backpressure: req1 AND a=0xF0F0F0F0 b=0x0F0F0F0F, resp_ready=0 for 5 cycles -> resp_valid, resp_result=0, resp_zero=1, resp_id=1 stable all 5 cycles; req0_ready/req1_ready stay 0.
REQ-033 Wrap: req0 ADD a=0xFFFFFFFF b=1 -> resp_result=0, resp_zero=1; follow-on request accepted no earlier than the cycle after the handshake.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester ALU arbiter: grants one request, executes it over LATENCY cycles, holds the result until accepted.
// Define ALU_ARBITER_FIXED_PRIO_EN to make requester 0 always win contention (no round-robin pointer).
module alu_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic        resp_zero,
    input  logic        resp_ready
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        id_q;
    logic        any_vld, gnt_id, exec_last;
    logic [31:0] alu;

    assign any_vld   = req0_valid | req1_valid;
    assign exec_last = (cnt == 2'(LATENCY - 1));

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    assign gnt_id = !req0_valid;
`else
    logic ptr;
    assign gnt_id = (req0_valid && req1_valid) ? ptr : !req0_valid;
`endif

    always_comb begin
        case (op_q)
            2'b00:   alu = a_q & b_q;
            2'b01:   alu = a_q | b_q;
            2'b10:   alu = a_q + b_q;
            default: alu = a_q - b_q;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: if (any_vld && !rst) begin
                req0_ready = !gnt_id;
                req1_ready = gnt_id;
                state_nxt  = EXEC;
            end
            EXEC: if (exec_last) state_nxt = DONE;
            DONE: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign resp_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
            ptr         <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            // Operands are captured at grant so later input changes cannot leak in.
            if (state == IDLE && any_vld) begin
                cnt  <= '0;
                id_q <= gnt_id;
                op_q <= gnt_id ? req1_op : req0_op;
                a_q  <= gnt_id ? req1_a  : req0_a;
                b_q  <= gnt_id ? req1_b  : req0_b;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
                ptr  <= !gnt_id;
`endif
            end
            if (state == EXEC) begin
                if (exec_last) begin
                    resp_result <= alu;
                    resp_zero   <= (alu == 32'd0);
                    resp_id     <= id_q;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-timeline model.
module tb_alu_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_id, resp_zero, resp_ready;
    logic [31:0] resp_result;

    always #5 clk = ~clk;

    alu_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result), .resp_zero(resp_zero),
        .resp_ready(resp_ready)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a + b;
            default: return a - b;
        endcase
    endfunction

    // Model: m_age counts cycles since acceptance; 1..LAT execute, LAT+1 is the response phase.
    bit          m_known = 0, m_busy = 0, m_ptr = 0, m_pid, m_id, m_zero;
    int          m_age;
    logic [31:0] m_pend, m_res;
    bit          obs_r0, obs_r1, obs_rv, obs_id, obs_zero;
    logic [31:0] obs_res;

    task automatic step(input bit r,
                        input bit v0, input logic [1:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                        input bit v1, input logic [1:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                        input bit rr);
        bit e_r0, e_r1, g;
        @(posedge clk); #1;
        rst = r; resp_ready = rr;
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        e_r0 = 0; e_r1 = 0;
        if (!r && !m_busy && (v0 || v1)) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
            g = !v0;
`else
            g = (v0 && v1) ? m_ptr : !v0;
`endif
            if (g) e_r1 = 1; else e_r0 = 1;
        end
        @(negedge clk);
        obs_r0 = req0_ready; obs_r1 = req1_ready; obs_rv = resp_valid;
        obs_id = resp_id; obs_zero = resp_zero; obs_res = resp_result;
        chk("req0_ready", 32'(obs_r0), 32'(e_r0));
        chk("req1_ready", 32'(obs_r1), 32'(e_r1));
        if (m_known) begin
            chk("resp_valid", 32'(obs_rv), 32'(m_busy && m_age == LAT + 1));
            chk("resp_id", 32'(obs_id), 32'(m_id));
            chk("resp_result", obs_res, m_res);
            chk("resp_zero", 32'(obs_zero), 32'(m_zero));
        end
        if (r) begin
            m_known = 1; m_busy = 0; m_ptr = 0; m_res = 0; m_id = 0; m_zero = 0;
        end else if (!m_busy) begin
            if (e_r0 || e_r1) begin
                m_busy = 1; m_age = 1; m_pid = e_r1; m_ptr = !e_r1;
                m_pend = e_r1 ? alu_ref(o1, a1, b1) : alu_ref(o0, a0, b0);
            end
        end else if (m_age <= LAT) begin
            if (m_age == LAT) begin
                m_res = m_pend; m_id = m_pid; m_zero = (m_pend == 32'd0);
            end
            m_age++;
        end else if (rr) begin
            m_busy = 0;
        end
    endtask

    task automatic idle(input bit rr);
        step(0, 0, 2'd0, 32'd0, 32'd0, 0, 2'd0, 32'd0, 32'd0, rr);
    endtask

    task automatic do_reset();
        step(1, 0, 2'd0, 32'd0, 32'd0, 0, 2'd0, 32'd0, 32'd0, 0);
    endtask

    initial begin
        int gseq[4];
        int ng, lat, hs, acc;
        bit got;
        rst = 1; resp_ready = 0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;

        do_reset();
        do_reset();
        idle(0);
        chk("rst_resp_valid", 32'(obs_rv), 32'd0);
        chk("rst_resp_result", obs_res, 32'd0);

        // Contention: both requesters valid every cycle
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            step(0, 1, 2'd0, 32'hFF00FF00, 32'h0FF00FF0, 1, 2'd1, 32'h12340000, 32'h00005678, 1);
            if (obs_r0 || obs_r1) begin gseq[ng] = obs_r1 ? 1 : 0; ng++; end
        end
        chk("rr_grant_count", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
            chk("fixed_grant", 32'(gseq[i]), 32'd0);
`else
            chk("rr_grant", 32'(gseq[i]), 32'(i % 2));
`endif
        end

        // Single SUB: latency from accept to resp_valid
        do_reset();
        step(0, 1, 2'd3, 32'd5, 32'd7, 0, 2'd0, 32'd0, 32'd0, 1);
        chk("sub_accept", 32'(obs_r0), 32'd1);
        lat = 0; got = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            step(0, 0, 2'd2, 32'd99, 32'd1, 0, 2'd0, 32'd0, 32'd0, 1);
            if (obs_rv) begin got = 1; lat = i; end
        end
        chk("sub_latency", 32'(lat), 32'(LAT + 1));
        chk("sub_result", obs_res, 32'hFFFFFFFE);
        chk("sub_id", 32'(obs_id), 32'd0);
        chk("sub_zero", 32'(obs_zero), 32'd0);

        // Backpressure on requester 1 AND -> zero result
        step(0, 0, 2'd0, 32'd0, 32'd0, 1, 2'd0, 32'hF0F0F0F0, 32'h0F0F0F0F, 0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(0, 0, 2'd0, 32'd0, 32'd0, 0, 2'd0, 32'd0, 32'd0, 0);
            got = obs_rv;
        end
        chk("bp_reached", 32'(got), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 2'd1, 32'd1, 32'd2, 1, 2'd1, 32'd3, 32'd4, 0);
            chk("bp_valid", 32'(obs_rv), 32'd1);
            chk("bp_result", obs_res, 32'd0);
            chk("bp_zero", 32'(obs_zero), 32'd1);
            chk("bp_id", 32'(obs_id), 32'd1);
        end
        idle(1);

        // ADD wrap, requester 0 keeps asking: next accept only after the handshake cycle
        do_reset();
        step(0, 1, 2'd2, 32'hFFFFFFFF, 32'd1, 0, 2'd0, 32'd0, 32'd0, 1);
        hs = -1; acc = -1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            step(0, 1, 2'd2, 32'd3, 32'd4, 0, 2'd0, 32'd0, 32'd0, 1);
            if (obs_rv) begin
                hs = i;
                chk("wrap_result", obs_res, 32'd0);
                chk("wrap_zero", 32'(obs_zero), 32'd1);
            end
            if (obs_r0) acc = i;
        end
        chk("wrap_reaccept", 32'(acc - hs), 32'd1);
        for (int i = 0; i < 6; i++) idle(1);

        // Reset during the first execute cycle drops the operation
        step(0, 1, 2'd2, 32'd10, 32'd20, 0, 2'd0, 32'd0, 32'd0, 1);
        do_reset();
        got = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (obs_rv) got = 1;
        end
        chk("rst_exec_no_resp", 32'(got), 32'd0);
        chk("rst_exec_result", obs_res, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a0, b0, a1, b1;
            a0 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom);
            b0 = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'($urandom);
            a1 = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            b1 = ($urandom_range(0, 7) == 0) ? a1 : 32'($urandom);
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) < 6, 2'($urandom), a0, b0,
                 $urandom_range(0, 9) < 6, 2'($urandom), a1, b1,
                 $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
